// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder and its L1 clients.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Default word geometry, shared with the L1 cache controller instances.
  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

  // Widest port vector the one-hot helper can produce.
  localparam int MAX_PORTS = 32;

  // One-hot mask with bit idx set; callers size-cast it to their port count.
  function automatic logic [MAX_PORTS-1:0] onehot(input int unsigned idx);
    return {{(MAX_PORTS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/dmem_responder_rr_arbiter.sv
// Combinational round-robin picker: earliest requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             grant_valid,
  output logic [PTR_W-1:0] grant_idx
);

  // Scan from farthest to nearest so the port closest to ptr wins.
  always_comb begin
    int sum;
    logic [PTR_W-1:0] idx;
    sum         = 0;
    idx         = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= N) sum = sum - N;
      idx = PTR_W'(sum);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Shared data-memory target for NUM_PORTS L1 controllers: round-robin arbitration,
// fixed-latency single-word access, per-port ack, write invalidate broadcast.
//
// state  | meaning
// IDLE   | waiting for a request; grant, latch request, load latency timer
// ACCESS | timer counting down; memory touched when it reaches zero
// RESP   | ack to granted port, invalidate to the others on a write
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int LATENCY   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        dmem_rd_en,
  input  logic [NUM_PORTS-1:0]        dmem_wr_en,
  input  logic [NUM_PORTS*ADDR_W-1:0] dmem_address,
  input  logic [NUM_PORTS*DATA_W-1:0] data_to_dmem,
  output logic [NUM_PORTS*DATA_W-1:0] data_from_dmem,
  output logic [NUM_PORTS-1:0]        dmem_ack,
  output logic                        busy,
  output logic [NUM_PORTS-1:0]        inv_valid,
  output logic [ADDR_W-1:0]           inv_addr
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

  state_t                     state_q, state_d;
  logic [PTR_W-1:0]           rr_ptr;
  logic [PTR_W-1:0]           grant_q;
  logic                       wr_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [DATA_W-1:0]          wdata_q;
  logic [CNT_W-1:0]           lat_cnt;
  logic [NUM_PORTS-1:0]       ack_mask;
  logic [NUM_PORTS-1:0]       req;
  logic [NUM_PORTS-1:0]       grant_mask;
  logic                       grant_valid;
  logic [PTR_W-1:0]           grant_idx;
  logic                       access_done;
  logic [NUM_PORTS*DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0]          mem [0:(1<<ADDR_W)-1];

  // The port acked last cycle is masked for one IDLE cycle so a requester
  // dropping its request right after the ack is not served twice.
  assign req         = (dmem_rd_en | dmem_wr_en) & ~ack_mask;
  assign grant_mask  = NUM_PORTS'(onehot(32'(grant_q)));
  assign access_done = (state_q == ACCESS) && (lat_cnt == '0);
  assign data_from_dmem = rdata_q;

  rr_arbiter #(.N(NUM_PORTS), .PTR_W(PTR_W)) u_arb (
    .req         (req),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  if (lat_cnt == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; ack and invalidate are single-cycle in RESP.
  always_comb begin
    dmem_ack  = '0;
    inv_valid = '0;
    inv_addr  = '0;
    busy      = (state_q != IDLE);
    if (state_q == RESP) begin
      dmem_ack = grant_mask;
      if (wr_q) begin
        inv_valid = ~grant_mask;
        inv_addr  = addr_q;
      end
    end
  end

  // Request capture, latency down-counter, round-robin pointer and ack mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      grant_q  <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lat_cnt  <= '0;
      ack_mask <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_mask <= '0;
          if (grant_valid) begin
            grant_q <= grant_idx;
            wr_q    <= dmem_wr_en[grant_idx];
            addr_q  <= dmem_address[grant_idx*ADDR_W +: ADDR_W];
            wdata_q <= data_to_dmem[grant_idx*DATA_W +: DATA_W];
            lat_cnt <= LAT_LOAD;
          end
        end
        ACCESS: if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        RESP: begin
          rr_ptr   <= (grant_q == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
          ack_mask <= grant_mask;
        end
        default: ;
      endcase
    end
  end

  // Per-port read data, held until that port's next read completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else if (access_done && !wr_q) rdata_q[grant_q*DATA_W +: DATA_W] <= mem[addr_q];
  end

  // Storage array is not reset; a write lands only on the final ACCESS edge.
  always_ff @(posedge clk) begin
    if (!reset && access_done && wr_q) mem[addr_q] <= wdata_q;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Shared data-memory responder: the target end of the L1-to-dmem interface (dmem_rd_en / dmem_wr_en / dmem_address / data_to_dmem / data_from_dmem) for NUM_PORTS L1 cache controllers in the multicore system.
- Arbitrates concurrent requests round-robin and serves one word access at a time with a fixed, parameterised latency.
- Returns a per-port ack with registered read data.
- On every write, broadcasts an invalidate to all other ports so their L1 copies can be dropped.

Parameters:
- NUM_PORTS, 2, number of L1 requesters (>=2).
- ADDR_W, 10, word address width ({tag, index}); memory depth 2**ADDR_W words.
- DATA_W, 32, word width.
- LATENCY, 2, number of ACCESS-state cycles per access (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dmem_rd_en  in  NUM_PORTS  per-port read request.
- dmem_wr_en  in  NUM_PORTS  per-port write request.
- dmem_address  in  NUM_PORTS*ADDR_W  per-port word address; port p occupies slice [p*ADDR_W +: ADDR_W].
- data_to_dmem  in  NUM_PORTS*DATA_W  per-port write data.
- data_from_dmem  out  NUM_PORTS*DATA_W  per-port registered read data.
- dmem_ack  out  NUM_PORTS  one-cycle completion pulse per port.
- busy  out  1  high whenever the FSM is not in IDLE.
- inv_valid  out  NUM_PORTS  one-cycle invalidate pulse to each non-writing port.
- inv_addr  out  ADDR_W  address being invalidated; valid while any inv_valid bit is high.

Behaviour:
- Reset (async): FSM=IDLE, rr_ptr=0, lat_cnt=0, ack_mask=0. All outputs 0: data_from_dmem, dmem_ack, busy, inv_valid, inv_addr. Memory array is not reset; contents are unspecified until written.
- Request vector: req[p] = (dmem_rd_en[p] | dmem_wr_en[p]) & ~ack_mask[p]. If both rd and wr are high on one port, it is a write and the read is ignored.
- FSM states IDLE, ACCESS, RESP.
  - IDLE: if req != 0, the rr_arbiter selects grant port g, the earliest requesting port starting from rr_ptr and wrapping modulo NUM_PORTS. On the same edge, latch g, op, address and write data, load lat_cnt=LATENCY-1, go to ACCESS. If req == 0, stay in IDLE.
  - ACCESS: requester inputs are ignored; only the latched copies are used. If lat_cnt != 0, decrement it. If lat_cnt == 0:
    - read: mem[addr] is latched into data_from_dmem[g].
    - write: mem[addr] <= wdata.
    - Go to RESP.
  - RESP: dmem_ack[g]=1 for exactly this cycle.
    - On a write, inv_valid[q]=1 for every q != g and inv_addr=addr.
    - rr_ptr <= (g+1) mod NUM_PORTS. ack_mask <= onehot(g). Go to IDLE.
- ack_mask applies only in the IDLE cycle that directly follows RESP, and clears at the end of that cycle. A requester that deasserts the cycle after its ack is therefore never served twice. A requester that keeps its request asserted is served again starting one cycle later.
- Latency: request high in IDLE cycle n gives ack in cycle n+LATENCY+1, plus the wait for any in-flight access. With LATENCY=2 that is 3 cycles.
- Read data on data_from_dmem[p] holds until the next read completion to port p. Writes do not change it.
- Requester drops its request during ACCESS: the access still completes and the ack is still issued.
- Simultaneous requests from all ports: one is served per transaction in round-robin order; none is starved. Worst-case wait is (NUM_PORTS-1)*(LATENCY+2) cycles.
- Read and write to the same address from different ports: executed in grant order. A read after a write returns the new data.
- Address wrap: addresses are taken modulo 2**ADDR_W. There is no out-of-range case.
- Reset mid-ACCESS: FSM returns to IDLE immediately and no ack is issued. A write whose final ACCESS edge has not occurred is not performed.

Decomposition:
- Package dmem_pkg holds:
  - state_t enum {IDLE, ACCESS, RESP} (2-bit).
  - Localparams for default ADDR_W/DATA_W, shared with cache_subsystem_L1 instances.
  - Helper function onehot(idx).
- Sub-module rr_arbiter (parameter N):
  - Inputs req[N], ptr.
  - Outputs grant_valid and grant_idx.
  - Purely combinational.
  - Instantiated once.

Test Plan:
- Write then read, single port (LATENCY=2): P0 wr addr 0x05A data 0xDEADBEEF; P0 rd 0x05A → first ack in cycle 3; after the second ack, data_from_dmem[0]=0xDEADBEEF; inv_valid[1] pulses once with inv_addr=0x05A; inv_valid[0] stays 0.
- Simultaneous reads, both ports: P0 rd 0x001 and P1 rd 0x002 in the same cycle → P0 acked cycle 3, P1 acked cycle 7 (P0 request dropped after ack); rr_ptr=0 after both.
- Fairness under persistent requests: P0 and P1 hold requests for 20 cycles → acks alternate P0, P1, P0, P1, …; no port gets two consecutive acks.
- Cross-port write/read ordering: P1 wr 0x3FF=0x12345678, then P0 rd 0x3FF while P1's write is in flight → P0 ack returns 0x12345678; inv_valid[0] pulses in P1's RESP cycle.
- Reset mid-ACCESS: P0 wr 0x010=0xAAAA5555 with mem[0x010]=0x0; assert reset in the first ACCESS cycle → no ack; busy=0 immediately; subsequent P0 rd 0x010 returns 0x0.
- Request dropped and rd+wr together: P1 raises rd_en and wr_en together at 0x020 with data 0x0F0F0F0F, then drops both in ACCESS → exactly one ack; treated as write (mem[0x020]=0x0F0F0F0F); data_from_dmem[1] unchanged.
